// File: rtl/poly_add_arbiter.sv
// poly_add_arbiter
// Round-robin scheduler that shares one polynomial CLA adder among five
// operand sources. It grants one requester, drives the 5:1 operand mux
// selector, pulses add_start, waits for add_done and then acks the requester.
// Control only; no polynomial data passes through here.
//
// Optional feature: define ADD_ARB_TIMEOUT_EN to enable a WAIT-state
// watchdog. If TIMEOUT_CYCLES WAIT cycles pass without add_done, the
// operation is closed with ack and a coincident one-cycle err pulse.
// Without the macro, WAIT waits indefinitely and err is always 0.

module poly_add_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int SEL_W          = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   mux_sel,
  output logic               add_start,
  input  logic               add_done,
  output logic               busy,
  output logic               err
);

  // The operand mux in front of the adder is 5:1 with a 3-bit code.
  if (NUM_REQ != 5 || SEL_W != 3 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("poly_add_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [SEL_W-1:0]   last_reg;     // index served most recently
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   cand;
  logic               timeout_hit;

  // (base + off) mod NUM_REQ for off in 1..NUM_REQ
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                 input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SEL_W'(s);
  endfunction

  // Round-robin pick: first set req bit scanning upward from last+1 with wrap
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = wrap_idx(last_reg, off);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef ADD_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_reg;

  // Watchdog counts WAIT cycles; cleared in START so every WAIT begins at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_reg <= '0;
    end else if (state_reg == START) begin
      wd_reg <= '0;
    end else if (state_reg == WAIT) begin
      wd_reg <= wd_reg + 1'b1;
    end
  end

  // Timeout fires on the last permitted WAIT cycle unless add_done arrives
  always_comb begin
    timeout_hit = 1'b0;
    if (state_reg == WAIT && !add_done && wd_reg == WD_W'(TIMEOUT_CYCLES - 1))
      timeout_hit = 1'b1;
  end
`else
  // No watchdog: WAIT only ends on add_done
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // Next-state logic; add_done matters only in WAIT
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_found) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (add_done || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; grant/mux_sel are frozen from START to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= SEL_W'(NUM_REQ - 1);
      mux_sel   <= '0;
      grant     <= '0;
      ack       <= '0;
      add_start <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      add_start <= (state_reg == IDLE) && (state_next == START);
      busy      <= (state_next != IDLE);
      ack       <= '0;
      err       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            mux_sel <= pick_idx;
            grant   <= NUM_REQ'(1) << pick_idx;
          end
        end
        WAIT: begin
          if (state_next == DONE) begin
            ack <= grant;
            err <= timeout_hit;
          end
        end
        DONE: begin
          grant    <= '0;
          last_reg <= mux_sel;
        end
        default: ;
      endcase
    end
  end

endmodule
